// File: rtl/oam_bus_responder.sv
// Sprite attribute memory (OAM) with a CPU/DMA bus port and the PPU mode-2 sprite scan.
// The scan picks the first MAX_SEL entries whose Y range covers the current line.
module oam_bus_responder #(
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int          OAM_SIZE     = 160,
    parameter int          MAX_SEL      = 10,
    parameter int          ENTRY_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] db_addr,
    input  logic [7:0]  db_wdata,
    input  logic        db_wr,
    input  logic        db_rd,
    output logic [7:0]  db_rdata,
    output logic        db_sel,
    input  logic        oam_lock,
    input  logic [7:0]  ly,
    input  logic        tall_sprites,
    input  logic        scan_start,
    output logic        scan_busy,
    output logic        scan_done,
    output logic [3:0]  sel_count,
    input  logic [3:0]  sel_rd_addr,
    output logic [5:0]  sel_rd_idx
);

    localparam int          NUM_ENTRIES = OAM_SIZE / 4;
    localparam logic [15:0] OAM_END     = OAM_BASE + 16'(OAM_SIZE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [7:0] mem      [0:OAM_SIZE-1];
    logic [5:0] sel_list [0:MAX_SEL-1];

    logic [1:0] state;
    logic [5:0] entry;
    logic [3:0] phase;

    logic       hit;
    logic       blocked;
    logic [7:0] offset;

    logic [7:0] y_byte;
    logic [8:0] line;
    logic [8:0] y_top;
    logic [8:0] height;
    logic       match;
    logic       last_phase;
    logic       last_entry;
    logic       take;

    assign hit     = (db_addr >= OAM_BASE) && (db_addr < OAM_END);
    assign offset  = 8'(db_addr - OAM_BASE);
    assign blocked = oam_lock | scan_busy;

    assign scan_busy = (state == ST_SCAN);
    assign scan_done = (state == ST_DONE);

    // Y byte of the entry under evaluation; 9-bit compare so line+16 never wraps.
    assign y_byte     = mem[{entry, 2'b00}];
    assign line       = {1'b0, ly} + 9'd16;
    assign y_top      = {1'b0, y_byte};
    assign height     = tall_sprites ? 9'd16 : 9'd8;
    assign match      = (line >= y_top) && (line < y_top + height);
    assign last_phase = (phase == 4'(ENTRY_CYCLES - 1));
    assign last_entry = (entry == 6'(NUM_ENTRIES - 1));
    assign take       = scan_busy && last_phase && match && (sel_count < 4'(MAX_SEL));

    always_ff @(posedge clk) begin
        if (db_wr && hit && !blocked) begin
            mem[offset] <= db_wdata;
        end
    end

    // Non-blocking semantics give the pre-write byte on a same-cycle read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_rdata <= 8'h00;
            db_sel   <= 1'b0;
        end else begin
            db_sel <= db_rd & hit;
            if (db_rd && hit) begin
                db_rdata <= blocked ? 8'hFF : mem[offset];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            entry     <= 6'd0;
            phase     <= 4'd0;
            sel_count <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (scan_start) begin
                        state     <= ST_SCAN;
                        entry     <= 6'd0;
                        phase     <= 4'd0;
                        sel_count <= 4'd0;
                    end
                end
                ST_SCAN: begin
                    if (last_phase) begin
                        phase <= 4'd0;
                        if (take) begin
                            sel_count <= sel_count + 4'd1;
                        end
                        if (last_entry) begin
                            state <= ST_DONE;
                        end else begin
                            entry <= entry + 6'd1;
                        end
                    end else begin
                        phase <= phase + 4'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (take) begin
            for (int i = 0; i < MAX_SEL; i++) begin
                if (sel_count == 4'(i)) begin
                    sel_list[i] <= entry;
                end
            end
        end
    end

    // Slots past the current count read as 6'h3F so stale list contents never leak out.
    always_comb begin
        sel_rd_idx = 6'h3F;
        for (int i = 0; i < MAX_SEL; i++) begin
            if ((sel_rd_addr == 4'(i)) && (4'(i) < sel_count)) begin
                sel_rd_idx = sel_list[i];
            end
        end
    end

endmodule

// File: tb/tb_oam_bus_responder.sv
// Scoreboard bench for oam_bus_responder: bus reads are queued at issue time and
// popped by a monitor on db_sel; sprite scans are checked against a list model.
module tb_oam_bus_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] db_addr;
    logic [7:0]  db_wdata;
    logic        db_wr;
    logic        db_rd;
    logic [7:0]  db_rdata;
    logic        db_sel;
    logic        oam_lock;
    logic [7:0]  ly;
    logic        tall_sprites;
    logic        scan_start;
    logic        scan_busy;
    logic        scan_done;
    logic [3:0]  sel_count;
    logic [3:0]  sel_rd_addr;
    logic [5:0]  sel_rd_idx;

    oam_bus_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .db_addr      (db_addr),
        .db_wdata     (db_wdata),
        .db_wr        (db_wr),
        .db_rd        (db_rd),
        .db_rdata     (db_rdata),
        .db_sel       (db_sel),
        .oam_lock     (oam_lock),
        .ly           (ly),
        .tall_sprites (tall_sprites),
        .scan_start   (scan_start),
        .scan_busy    (scan_busy),
        .scan_done    (scan_done),
        .sel_count    (sel_count),
        .sel_rd_addr  (sel_rd_addr),
        .sel_rd_idx   (sel_rd_idx)
    );

    always #5 clk = ~clk;

    logic [7:0] model_mem [0:159];
    logic [7:0] exp_q [$];
    logic [7:0] model_rdata;
    logic [7:0] mon_exp;
    int         exp_list [$];
    int         vectors     = 0;
    int         miscompares = 0;

    int bnd_y    [8] = '{37, 36, 28, 28, 20, 0, 0, 29};
    bit bnd_tall [8] = '{0, 0, 0, 1, 1, 0, 1, 0};

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic bit in_oam(input logic [15:0] a);
        return (a >= 16'hFE00) && (a <= 16'hFE9F);
    endfunction

    // Drives one bus cycle; the strobe is sampled at the following rising edge.
    task automatic apply_stimulus(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
        int off;
        off = int'(a) - 'hFE00;
        @(posedge clk);
        #1;
        db_addr  = a;
        db_wdata = d;
        db_rd    = rd;
        db_wr    = wr;
        if (in_oam(a)) begin
            if (rd) exp_q.push_back(oam_lock ? 8'hFF : model_mem[off]);
            if (wr && !oam_lock) model_mem[off] = d;
        end
    endtask

    task automatic bus_idle();
        apply_stimulus(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic write_y(input int e, input logic [7:0] y);
        apply_stimulus(1'b0, 1'b1, 16'hFE00 + 16'(e * 4), y);
    endtask

    task automatic scan_model();
        exp_list.delete();
        for (int e = 0; e < 40; e++) begin
            int y;
            int ln;
            int h;
            y  = int'(model_mem[e * 4]);
            ln = int'(ly) + 16;
            h  = tall_sprites ? 16 : 8;
            if (ln >= y && ln < y + h && exp_list.size() < 10) exp_list.push_back(e);
        end
    endtask

    task automatic run_scan(input int restart_at, input int reset_at, input int blocked_at, input string tag);
        int busy_cycles = 0;
        int done_cycles = 0;
        int first_done  = -1;
        int want;
        scan_model();
        @(negedge clk);
        scan_start = 1'b1;
        @(negedge clk);
        scan_start = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            if (scan_busy === 1'b1) busy_cycles++;
            if (scan_done === 1'b1) begin
                done_cycles++;
                if (first_done < 0) first_done = c;
            end
            scan_start = (c == restart_at);
            if (blocked_at > 0 && c == blocked_at) begin
                db_addr  = 16'hFE9C;
                db_wdata = ~model_mem[156];
                db_rd    = 1'b1;
                db_wr    = 1'b1;
                exp_q.push_back(8'hFF);
            end else begin
                db_rd = 1'b0;
                db_wr = 1'b0;
            end
            if (reset_at > 0 && c == reset_at) rst_n = 1'b0;
            if (reset_at > 0 && c == reset_at + 1) begin
                sel_rd_addr = 4'd0;
                #1;
                check_output({tag, "_busy_in_reset"}, scan_busy, 1'b0);
                check_output({tag, "_count_in_reset"}, sel_count, 4'd0);
                check_output({tag, "_rdata_in_reset"}, db_rdata, 8'h00);
                check_output({tag, "_idx_in_reset"}, sel_rd_idx, 6'h3F);
                model_rdata = 8'h00;
            end
            if (reset_at > 0 && c == reset_at + 2) rst_n = 1'b1;
            @(negedge clk);
        end
        scan_start = 1'b0;
        db_rd      = 1'b0;
        db_wr      = 1'b0;
        if (reset_at > 0) begin
            check_output({tag, "_busy_cycles"}, busy_cycles, reset_at);
            check_output({tag, "_done_cycles"}, done_cycles, 0);
            check_output({tag, "_count"}, sel_count, 4'd0);
        end else begin
            check_output({tag, "_busy_cycles"}, busy_cycles, 80);
            check_output({tag, "_done_at"}, first_done, 81);
            check_output({tag, "_done_cycles"}, done_cycles, 1);
            check_output({tag, "_count"}, sel_count, exp_list.size());
            for (int s = 0; s < 16; s++) begin
                sel_rd_addr = 4'(s);
                #1;
                want = (s < exp_list.size()) ? exp_list[s] : 63;
                check_output({tag, "_slot"}, sel_rd_idx, want);
            end
        end
    endtask

    // Every db_sel cycle must match exactly one queued read.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && db_sel !== 1'b0) begin
                if (exp_q.size() == 0) begin
                    check_output("unexpected_db_sel", db_sel, 1'b0);
                end else begin
                    mon_exp     = exp_q.pop_front();
                    model_rdata = mon_exp;
                    check_output("db_rdata", db_rdata, mon_exp);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n        = 1'b0;
        db_addr      = 16'h0000;
        db_wdata     = 8'h00;
        db_wr        = 1'b0;
        db_rd        = 1'b0;
        oam_lock     = 1'b0;
        ly           = 8'd0;
        tall_sprites = 1'b0;
        scan_start   = 1'b0;
        sel_rd_addr  = 4'd0;
        model_rdata  = 8'h00;

        repeat (3) @(negedge clk);
        check_output("reset_rdata", db_rdata, 8'h00);
        check_output("reset_sel", db_sel, 1'b0);
        check_output("reset_busy", scan_busy, 1'b0);
        check_output("reset_done", scan_done, 1'b0);
        check_output("reset_count", sel_count, 4'd0);
        check_output("reset_idx", sel_rd_idx, 6'h3F);
        rst_n = 1'b1;

        for (int i = 0; i < 160; i++) apply_stimulus(1'b0, 1'b1, 16'hFE00 + 16'(i), 8'($urandom));
        for (int i = 0; i < 160; i++) apply_stimulus(1'b1, 1'b0, 16'hFE00 + 16'(i), 8'h00);
        repeat (2) bus_idle();

        apply_stimulus(1'b0, 1'b1, 16'hFE10, 8'hA5);
        bus_idle();
        oam_lock = 1'b1;
        apply_stimulus(1'b0, 1'b1, 16'hFE10, 8'h3C);
        apply_stimulus(1'b1, 1'b0, 16'hFE10, 8'h00);
        bus_idle();
        oam_lock = 1'b0;
        apply_stimulus(1'b1, 1'b0, 16'hFE10, 8'h00);
        bus_idle();

        apply_stimulus(1'b1, 1'b1, 16'hFE20, model_mem[32] ^ 8'h5A);
        apply_stimulus(1'b1, 1'b0, 16'hFE20, 8'h00);
        repeat (2) bus_idle();

        apply_stimulus(1'b1, 1'b1, 16'hFDFF, 8'h55);
        apply_stimulus(1'b1, 1'b1, 16'hFEA0, 8'hAA);
        repeat (3) bus_idle();
        check_output("nohit_rdata_held", db_rdata, model_rdata);
        for (int i = 0; i < 160; i++) apply_stimulus(1'b1, 1'b0, 16'hFE00 + 16'(i), 8'h00);
        repeat (2) bus_idle();

        ly           = 8'd20;
        tall_sprites = 1'b0;
        for (int e = 0; e < 40; e++) write_y(e, (e < 12) ? 8'd36 : 8'd0);
        bus_idle();
        run_scan(0, 0, 0, "main");
        check_output("main_count_ten", sel_count, 4'd10);

        run_scan(10, 0, 20, "restart");
        apply_stimulus(1'b1, 1'b0, 16'hFE9C, 8'h00);
        repeat (2) bus_idle();

        for (int e = 0; e < 40; e++) write_y(e, 8'd0);
        for (int b = 0; b < 8; b++) begin
            ly           = 8'd20;
            tall_sprites = bnd_tall[b];
            write_y(7, 8'(bnd_y[b]));
            bus_idle();
            run_scan(0, 0, 0, "boundary");
        end

        for (int r = 0; r < 4; r++) begin
            ly           = 8'($urandom_range(0, 60));
            tall_sprites = 1'($urandom_range(0, 1));
            for (int e = 0; e < 40; e++) write_y(e, 8'($urandom_range(8, 90)));
            bus_idle();
            run_scan(0, 0, 0, "random");
        end

        run_scan(0, 40, 0, "midreset");
        for (int i = 0; i < 16; i++) apply_stimulus(1'b1, 1'b0, 16'hFE00 + 16'(i), 8'h00);
        repeat (4) bus_idle();
        check_output("pending_reads", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
